regfile_mp: RTL and testbench

//  Multi-port, parametrised integer register file for the next-generation core datapath.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 63 ++++++
 rtl/regfile_mp.sv | 107 ++++++++++
 tb/tb_regfile_mp.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
//   Shared defaults and types for the multi-port register file.
//   DEF_XLEN / DEF_NREGS : default data width and register count
//   reg_addr_t / reg_data_t : address and data types at the default sizes
//   ZERO_REG : architectural zero register (hard-wired to 0, never busy)
// -----------------------------------------------------------------------------
package regfile_pkg;

  localparam int unsigned DEF_XLEN  = 32;
  localparam int unsigned DEF_NREGS = 32;
  localparam int unsigned DEF_AW    = $clog2(DEF_NREGS);

  typedef logic [DEF_AW-1:0]   reg_addr_t;
  typedef logic [DEF_XLEN-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = '0;

endpackage : regfile_pkg

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//   One busy bit per architectural register. A reservation marks a register
//   busy; a writeback to it clears it. When both hit the same register on one
//   edge the reservation wins, since it names a newer producer.
//   Register 0 can never become busy.
// Ports
//   clk, reset         rising-edge clock, asynchronous active-high reset
//   we, wa             writeback enables / addresses (clear busy)
//   rsv_valid/rsv_addr reservation request (set busy)
//   ra                 read-port addresses to look up
//   busy_rd            stored busy bit for each read port
// -----------------------------------------------------------------------------
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NWRITE-1:0]                we,
  input  logic [NWRITE*$clog2(NREGS)-1:0]  wa,
  input  logic                             rsv_valid,
  input  logic [$clog2(NREGS)-1:0]         rsv_addr,
  input  logic [NREAD*$clog2(NREGS)-1:0]   ra,
  output logic [NREAD-1:0]                 busy_rd
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_set;
  logic [NREGS-1:0] busy_clr;

  // NOTE: every signal driven in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (rsv_valid && rsv_addr != ZERO_ADDR)
      busy_set[rsv_addr] = 1'b1;
    for (int j = 0; j < NWRITE; j++) begin
      if (we[j] && wa[j*AW +: AW] != ZERO_ADDR)
        busy_clr[wa[j*AW +: AW]] = 1'b1;
    end
  end

  // Set is OR-ed in after the clear, so a same-edge reserve keeps the bit set.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) busy <= '0;
    else       busy <= (busy & ~busy_clr) | busy_set;
  end

  always_comb begin
    busy_rd = '0;
    for (int i = 0; i < NREAD; i++)
      busy_rd[i] = busy[ra[i*AW +: AW]];
  end

endmodule : regfile_scoreboard

// File: rtl/regfile_mp.sv
// -----------------------------------------------------------------------------
// regfile_mp
//   Multi-port integer register file with per-register busy scoreboard.
//   NREAD combinational read ports, NWRITE synchronous write ports,
//   register 0 reads as zero and ignores writes/reservations.
//   On a same-address write conflict the highest write port index wins.
// Configuration macro
//   REGFILE_BYPASS_EN : forward same-cycle write data to matching read ports
//                       (highest write port wins) and report them not busy
//                       unless a same-cycle reservation targets them.
//                       Undefined: reads see stored state only.
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   ra  [NREAD*AW]      read addresses, port i at [i*AW +: AW]
//   rd  [NREAD*XLEN]    read data,      port i at [i*XLEN +: XLEN]
//   rbusy [NREAD]       pending-write flag of the register each port reads
//   we  [NWRITE]        write enables
//   wa  [NWRITE*AW]     write addresses
//   wd  [NWRITE*XLEN]   write data
//   rsv_valid, rsv_addr reserve (mark busy) a register at the next edge
// -----------------------------------------------------------------------------
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned XLEN   = DEF_XLEN,
  parameter int unsigned NREGS  = DEF_NREGS,
  parameter int unsigned NREAD  = 2,
  parameter int unsigned NWRITE = 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NREAD*$clog2(NREGS)-1:0]   ra,
  output logic [NREAD*XLEN-1:0]            rd,
  output logic [NREAD-1:0]                 rbusy,
  input  logic [NWRITE-1:0]                we,
  input  logic [NWRITE*$clog2(NREGS)-1:0]  wa,
  input  logic [NWRITE*XLEN-1:0]           wd,
  input  logic                             rsv_valid,
  input  logic [$clog2(NREGS)-1:0]         rsv_addr
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam logic [AW-1:0] ZERO_ADDR = AW'(ZERO_REG);

  logic [XLEN-1:0] mem [NREGS];
  logic [NREAD-1:0] sb_busy;

  // NOTE: the storage array is cleared by the asynchronous reset because the
  // architecture requires every register to read zero during and after reset.
  // NOTE: sequential state uses non-blocking assignments; within one edge the
  // last scheduled update to an entry wins, which gives the highest write
  // port priority on an address conflict.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int n = 0; n < NREGS; n++) mem[n] <= '0;
    end else begin
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wa[j*AW +: AW] != ZERO_ADDR)
          mem[wa[j*AW +: AW]] <= wd[j*XLEN +: XLEN];
      end
    end
  end

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_scoreboard (
    .clk       (clk),
    .reset     (reset),
    .we        (we),
    .wa        (wa),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr),
    .ra        (ra),
    .busy_rd   (sb_busy)
  );

  logic [AW-1:0]   rd_addr;
  logic [XLEN-1:0] rd_val;
  logic            rd_bsy;

  always_comb begin
    rd      = '0;
    rbusy   = '0;
    rd_addr = '0;
    rd_val  = '0;
    rd_bsy  = 1'b0;
    for (int i = 0; i < NREAD; i++) begin
      rd_addr = ra[i*AW +: AW];
      rd_val  = (rd_addr == ZERO_ADDR) ? '0 : mem[rd_addr];
      rd_bsy  = sb_busy[i];
`ifdef REGFILE_BYPASS_EN
      // Ascending scan: a higher write port overrides a lower one.
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wa[j*AW +: AW] == rd_addr && rd_addr != ZERO_ADDR) begin
          rd_val = wd[j*XLEN +: XLEN];
          rd_bsy = rsv_valid && (rsv_addr == rd_addr);
        end
      end
`endif
      rd[i*XLEN +: XLEN] = rd_val;
      rbusy[i]           = rd_bsy;
    end
  end

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// -----------------------------------------------------------------------------
// tb_regfile_mp
//   Self-checking bench for regfile_mp (2 read ports, 2 write ports).
//   Expected read results are queued as stimulus is driven and compared when
//   the DUT outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int XLEN   = 32;
  localparam int NREGS  = 32;
  localparam int NREAD  = 2;
  localparam int NWRITE = 2;
  localparam int AW     = 5;

  logic                   clk;
  logic                   reset;
  logic [NREAD*AW-1:0]    ra;
  logic [NREAD*XLEN-1:0]  rd;
  logic [NREAD-1:0]       rbusy;
  logic [NWRITE-1:0]      we;
  logic [NWRITE*AW-1:0]   wa;
  logic [NWRITE*XLEN-1:0] wd;
  logic                   rsv_valid;
  logic [AW-1:0]          rsv_addr;

  regfile_mp #(
    .XLEN (XLEN), .NREGS (NREGS), .NREAD (NREAD), .NWRITE (NWRITE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rbusy     (rbusy),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .rsv_valid (rsv_valid),
    .rsv_addr  (rsv_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  typedef struct {
    string       name;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  // Reference state for the random phase.
  logic [31:0] m_mem  [NREGS];
  logic        m_busy [NREGS];

  // ---------------------------------------------------------------- helpers
  task automatic clear_inputs();
    we = '0; wa = '0; wd = '0; rsv_valid = 1'b0; rsv_addr = '0;
  endtask

  task automatic set_w(input int j, input logic en, input logic [AW-1:0] a,
                       input logic [31:0] d);
    we[j]             = en;
    wa[j*AW +: AW]    = a;
    wd[j*XLEN +: XLEN] = d;
  endtask

  task automatic set_ra(input int i, input logic [AW-1:0] a);
    ra[i*AW +: AW] = a;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_rd(input string name, input int port,
                           input logic [31:0] d, input logic b);
    exp_t e;
    e.name = name; e.port = port; e.data = d; e.busy = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: compares every queued expectation against the
  // current DUT outputs.
  task automatic drain();
    exp_t e;
    logic [31:0] got_d;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got_d = rd[e.port*XLEN +: XLEN];
      n_checks++;
      if (got_d !== e.data) begin
        n_fail++;
        $display("FAIL %s rd[%0d]: got %h expected %h", e.name, e.port, got_d, e.data);
      end
      n_checks++;
      if (rbusy[e.port] !== e.busy) begin
        n_fail++;
        $display("FAIL %s rbusy[%0d]: got %b expected %b", e.name, e.port,
                 rbusy[e.port], e.busy);
      end
    end
  endtask

  // ------------------------------------------------------------------ tests
  task automatic test_reset();
    reset = 1'b1;
    clear_inputs();
    ra = '0;
    set_ra(0, 5); set_ra(1, 6);
    #2;
    expect_rd("reset_hold", 0, 32'h0, 1'b0);
    expect_rd("reset_hold", 1, 32'h0, 1'b0);
    drain();
    #1 reset = 1'b0;
    // Write reg5 and reserve reg6, then reset asynchronously mid-cycle.
    set_w(0, 1'b1, 5, 32'hDEADBEEF);
    rsv_valid = 1'b1; rsv_addr = 6;
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("pre_reset", 0, 32'hDEADBEEF, 1'b0);
    expect_rd("pre_reset", 1, 32'h0, 1'b1);
    drain();
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if (rd[31:0] !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset rd[0]: got %h expected 00000000", rd[31:0]);
    end
    n_checks++;
    if (rbusy !== 2'b00) begin
      n_fail++;
      $display("FAIL async_reset rbusy: got %b expected 00", rbusy);
    end
    #1 reset = 1'b0;
    // First edge after release must act normally.
    set_w(0, 1'b1, 5, 32'h00000001);
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("post_reset", 0, 32'h00000001, 1'b0);
    expect_rd("post_reset", 1, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_write_read();
    step();
    set_w(0, 1'b1, 3, 32'h12345678);
    step();
    clear_inputs();
    set_ra(0, 3); set_ra(1, 0);
    @(negedge clk);
    expect_rd("write_read", 0, 32'h12345678, 1'b0);
    expect_rd("write_read", 1, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_x0();
    step();
    set_w(0, 1'b1, 0, 32'hFFFFFFFF);
    rsv_valid = 1'b1; rsv_addr = 0;
    set_ra(0, 0); set_ra(1, 0);
    @(negedge clk);
    expect_rd("x0_same_cycle", 0, 32'h0, 1'b0);
    drain();
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("x0_after", 0, 32'h0, 1'b0);
    expect_rd("x0_after", 1, 32'h0, 1'b0);
    drain();
  endtask

  task automatic test_conflict();
    step();
    set_w(0, 1'b1, 7, 32'h0000AAAA);
    set_w(1, 1'b1, 7, 32'h00005555);
    step();
    set_w(0, 1'b1, 10, 32'hCAFE0010);
    set_w(1, 1'b1, 11, 32'hCAFE0011);
    step();
    clear_inputs();
    set_ra(0, 7); set_ra(1, 10);
    @(negedge clk);
    expect_rd("conflict_hi_wins", 0, 32'h00005555, 1'b0);
    expect_rd("dual_write_p0", 1, 32'hCAFE0010, 1'b0);
    drain();
    set_ra(1, 11);
    #1;
    expect_rd("dual_write_p1", 1, 32'hCAFE0011, 1'b0);
    drain();
  endtask

  task automatic test_scoreboard();
    step();
    rsv_valid = 1'b1; rsv_addr = 9;
    set_ra(0, 9); set_ra(1, 8);
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("sb_reserved", 0, 32'h0, 1'b1);
    expect_rd("sb_other_idle", 1, 32'h0, 1'b0);
    drain();
    // Reserve again while busy.
    step();
    rsv_valid = 1'b1; rsv_addr = 9;
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("sb_rereserve", 0, 32'h0, 1'b1);
    drain();
    // Write and reserve on the same edge: reservation wins.
    step();
    set_w(0, 1'b1, 9, 32'h00000099);
    rsv_valid = 1'b1; rsv_addr = 9;
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("sb_set_wins", 0, 32'h00000099, 1'b1);
    drain();
    // Plain writeback clears busy.
    step();
    set_w(1, 1'b1, 9, 32'h0000009A);
    @(negedge clk);
    expect_rd("sb_wb_same_cycle", 0, BYPASS ? 32'h0000009A : 32'h00000099, !BYPASS);
    drain();
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("sb_cleared", 0, 32'h0000009A, 1'b0);
    drain();
  endtask

  task automatic test_bypass();
    step();
    set_w(0, 1'b1, 4, 32'h00000011);
    step();
    clear_inputs();
    set_w(0, 1'b1, 4, 32'h00000077);
    set_ra(0, 4); set_ra(1, 4);
    @(negedge clk);
    expect_rd("bypass_rd", 0, BYPASS ? 32'h00000077 : 32'h00000011, 1'b0);
    drain();
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("bypass_after", 0, 32'h00000077, 1'b0);
    drain();
    // Write plus reservation of the read register in the same cycle.
    set_w(1, 1'b1, 4, 32'h00000088);
    rsv_valid = 1'b1; rsv_addr = 4;
    #1;
    expect_rd("bypass_rsv", 1, BYPASS ? 32'h00000088 : 32'h00000077, BYPASS);
    drain();
    step();
    clear_inputs();
    @(negedge clk);
    expect_rd("bypass_rsv_after", 1, 32'h00000088, 1'b1);
    drain();
  endtask

  task automatic test_random();
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          b;
    // Resynchronise DUT and model from the all-zero reset state.
    step();
    reset = 1'b1;
    #1 reset = 1'b0;
    for (int n = 0; n < NREGS; n++) begin
      m_mem[n] = '0; m_busy[n] = 1'b0;
    end
    for (int c = 0; c < 60; c++) begin
      for (int j = 0; j < NWRITE; j++)
        set_w(j, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom);
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = AW'($urandom_range(0, 7));
      for (int i = 0; i < NREAD; i++) set_ra(i, AW'($urandom_range(0, 7)));
      for (int i = 0; i < NREAD; i++) begin
        a = ra[i*AW +: AW];
        d = (a == 0) ? 32'h0 : m_mem[a];
        b = (a == 0) ? 1'b0 : m_busy[a];
        if (BYPASS) begin
          for (int j = 0; j < NWRITE; j++) begin
            if (we[j] && wa[j*AW +: AW] == a && a != 0) begin
              d = wd[j*XLEN +: XLEN];
              b = rsv_valid && (rsv_addr == a);
            end
          end
        end
        expect_rd("random", i, d, b);
      end
      @(negedge clk);
      drain();
      for (int j = 0; j < NWRITE; j++) begin
        if (we[j] && wa[j*AW +: AW] != 0) begin
          m_mem[wa[j*AW +: AW]]  = wd[j*XLEN +: XLEN];
          m_busy[wa[j*AW +: AW]] = 1'b0;
        end
      end
      if (rsv_valid && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      step();
    end
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_write_read();
    test_x0();
    test_conflict();
    test_scoreboard();
    test_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp
